// File: rtl/bnn_window_sched_if.sv
// Window-in / result-out stream bundle for the BNN window scheduler.
//   in_valid/in_ready/in_img          : 7x7 binary window offered by the fetch logic
//   out_valid/out_ready/out_sum/out_bit : thresholded result to the next layer
// master = window producer / result consumer, slave = scheduler.
interface bnn_window_sched_if #(
    parameter int unsigned WIN_BITS = 49,
    parameter int unsigned SUM_W    = 7
);
    logic                in_valid;
    logic                in_ready;
    logic [WIN_BITS-1:0] in_img;
    logic                out_valid;
    logic                out_ready;
    logic [SUM_W-1:0]    out_sum;
    logic                out_bit;

    modport master (
        output in_valid, in_img, out_ready,
        input  in_ready, out_valid, out_sum, out_bit
    );

    modport slave (
        input  in_valid, in_img, out_ready,
        output in_ready, out_valid, out_sum, out_bit
    );
endinterface

// File: rtl/bnn_window_sched.sv
// Scheduler for the binary XNOR/popcount row datapath. Latches one window,
// drives clear + ROWS accumulate steps, captures and thresholds the sum and
// holds the result on a valid/ready output.
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : window input and result output streams
//   w_load/w_ready/w_data : weight kernel load (accepted only in IDLE)
//   thresh        : signed threshold, sampled in SETTLE
//   dp_clr/dp_step/dp_img/dp_w/dp_sum : datapath control and result
//   busy, win_cnt : activity flag and completed-output count
module bnn_window_sched #(
    parameter int unsigned WIN_BITS = 49,
    parameter int unsigned ROWS     = 7,
    parameter int unsigned SUM_W    = 7,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    bnn_window_sched_if.slave   bus,
    input  logic                w_load,
    output logic                w_ready,
    input  logic [WIN_BITS-1:0] w_data,
    input  logic [SUM_W-1:0]    thresh,
    output logic                dp_clr,
    output logic                dp_step,
    output logic [WIN_BITS-1:0] dp_img,
    output logic [WIN_BITS-1:0] dp_w,
    input  logic [SUM_W-1:0]    dp_sum,
    output logic                busy,
    output logic [CNT_W-1:0]    win_cnt
);
    localparam int unsigned    ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SETTLE,
        S_OUT
    } state_t;

    state_t           state, state_nx;
    logic [ROW_W-1:0] row, row_nx;

    // State and row counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            row   <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        row_nx   = row;
        case (state)
            S_IDLE:   if (bus.in_valid) state_nx = S_CLEAR;
            S_CLEAR: begin
                state_nx = S_ACCUM;
                row_nx   = '0;
            end
            S_ACCUM: begin
                row_nx = row + ROW_W'(1);
                if (row == ROW_LAST) state_nx = S_SETTLE;
            end
            S_SETTLE: state_nx = S_OUT;
            S_OUT:    if (bus.out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_clr        <= 1'b0;
            dp_step       <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b1;
            w_ready       <= 1'b1;
        end else begin
            dp_clr        <= (state_nx == S_CLEAR);
            dp_step       <= (state_nx == S_ACCUM);
            bus.out_valid <= (state_nx == S_OUT);
            busy          <= (state_nx != S_IDLE);
            bus.in_ready  <= (state_nx == S_IDLE);
            w_ready       <= (state_nx == S_IDLE);
        end
    end

    // Window/weight latches, result capture and output counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_img      <= '0;
            dp_w        <= '0;
            bus.out_sum <= '0;
            bus.out_bit <= 1'b0;
            win_cnt     <= '0;
        end else begin
            if (state == S_IDLE && bus.in_valid) dp_img <= bus.in_img;
            if (state == S_IDLE && w_load)       dp_w   <= w_data;
            if (state == S_SETTLE) begin
                bus.out_sum <= dp_sum;
                bus.out_bit <= ($signed(dp_sum) >= $signed(thresh));
            end
            if (state == S_OUT && bus.out_ready) win_cnt <= win_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bnn_window_sched.sv
// Self-checking bench for bnn_window_sched: table vectors, hand-written
// timing/backpressure/reset sequences, random windows against a popcount
// reference, and a streaming run that wraps the window counter.
module tb_bnn_window_sched;
    localparam int unsigned WIN_BITS = 49;
    localparam int unsigned SUM_W    = 7;
    localparam int unsigned CNT_W    = 4;
    localparam logic [48:0] ALL1     = '1;

    logic                clk = 1'b0;
    logic                rst;
    logic                w_load;
    logic                w_ready;
    logic [WIN_BITS-1:0] w_data;
    logic [SUM_W-1:0]    thresh;
    logic                dp_clr;
    logic                dp_step;
    logic [WIN_BITS-1:0] dp_img;
    logic [WIN_BITS-1:0] dp_w;
    logic [SUM_W-1:0]    dp_sum;
    logic                busy;
    logic [CNT_W-1:0]    win_cnt;

    bnn_window_sched_if #(.WIN_BITS(WIN_BITS), .SUM_W(SUM_W)) bus ();

    bnn_window_sched #(.CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .w_load  (w_load),
        .w_ready (w_ready),
        .w_data  (w_data),
        .thresh  (thresh),
        .dp_clr  (dp_clr),
        .dp_step (dp_step),
        .dp_img  (dp_img),
        .dp_w    (dp_w),
        .dp_sum  (dp_sum),
        .busy    (busy),
        .win_cnt (win_cnt)
    );

    always #5 clk = ~clk;

    // Model XNOR/popcount datapath: each row adds (matches - mismatches)
    logic [6:0] acc;
    int         dp_row = 0;
    logic       force_en;
    logic [6:0] force_val;
    always @(posedge clk) begin
        if (dp_clr) begin
            acc    <= '0;
            dp_row <= 0;
        end else if (dp_step) begin
            acc    <= acc + 7'(2 * $countones(~(dp_img[dp_row*7 +: 7] ^ dp_w[dp_row*7 +: 7])) - 7);
            dp_row <= dp_row + 1;
        end
    end
    assign dp_sum = force_en ? force_val : acc;

    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;
    logic [48:0] cur_w = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One full window with out_ready released after bp stall cycles
    task automatic do_window(input logic [48:0] img, input logic ld, input logic [48:0] wd,
                             input logic [6:0] thr, input logic fen, input logic [6:0] fv,
                             input int bp, input logic junk,
                             output logic [6:0] s, output logic b);
        int lat;
        if (ld) cur_w = wd;
        check("hs_in_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1; bus.in_img = img; w_load = ld; w_data = wd;
        thresh = 7'($urandom); force_en = fen; force_val = fv; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_img = 49'({$urandom, $urandom}); w_load = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            w_load = junk && (lat == 6);
            w_data = ~cur_w;
            thresh = (lat == 9) ? thr : 7'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        w_load = 1'b0;
        check("latency", 64'(lat), 64'd10);
        check("dp_w_held", dp_w, cur_w);
        s = bus.out_sum;
        b = bus.out_bit;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {bus.out_valid, bus.out_bit, bus.out_sum}, {1'b1, b, s});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        check("win_cnt", win_cnt, 64'(exp_cnt % (1 << CNT_W)));
        check("back_idle", {bus.in_ready, bus.out_valid, busy}, 3'b100);
    endtask

    typedef struct {
        logic [48:0] img;
        logic [48:0] w;
        logic [6:0]  thr;
        logic        fen;
        logic [6:0]  fv;
        logic [6:0]  es;
        logic        eb;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [6:0]  s, es;
        logic        b, eb;
        logic [48:0] img, wd, x;
        logic        ld;
        int          lat;

        tbl[0] = '{ALL1,    ALL1,  7'd0,  1'b0, 7'h00, 7'd49, 1'b1};
        tbl[1] = '{49'h0,   ALL1,  7'h4F, 1'b0, 7'h00, 7'h4F, 1'b1};
        tbl[2] = '{ALL1,    49'h0, 7'h50, 1'b0, 7'h00, 7'h4F, 1'b0};
        tbl[3] = '{ALL1,    ALL1,  7'h7B, 1'b1, 7'h7B, 7'h7B, 1'b1};
        tbl[4] = '{ALL1,    ALL1,  7'h7B, 1'b1, 7'h7A, 7'h7A, 1'b0};
        tbl[5] = '{ALL1,    ALL1,  7'h40, 1'b1, 7'h3F, 7'h3F, 1'b1};
        tbl[6] = '{ALL1,    ALL1,  7'h3F, 1'b1, 7'h40, 7'h40, 1'b0};
        tbl[7] = '{49'h0,   49'h0, 7'd49, 1'b0, 7'h00, 7'd49, 1'b1};
        tbl[8] = '{49'h7F,  49'h0, 7'd36, 1'b0, 7'h00, 7'h23, 1'b0};

        rst = 1'b0; w_load = 1'b0; w_data = '0; thresh = '0; force_en = 1'b0; force_val = '0;
        bus.in_valid = 1'b0; bus.in_img = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {bus.out_valid, busy, dp_clr, dp_step, bus.out_bit}, 5'b0);
        check("rst_regs", {dp_img, dp_w, bus.out_sum, win_cnt}, 64'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {bus.in_ready, w_ready}, 2'b11);

        // All-ones window with simultaneous weight load, full timeline
        bus.in_valid = 1'b1; bus.in_img = ALL1; w_load = 1'b1; w_data = ALL1; thresh = 7'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; w_load = 1'b0; cur_w = ALL1;
        check("clr_dp_w", dp_w, ALL1);
        check("clr_dp_img", dp_img, ALL1);
        for (int c = 1; c <= 10; c++) begin
            check("tl_clr", dp_clr, 64'(c == 1));
            check("tl_step", dp_step, 64'(c >= 2 && c <= 8));
            check("tl_valid", bus.out_valid, 64'(c == 10));
            check("tl_ready", {bus.in_ready, w_ready}, 2'b00);
            if (c < 10) begin @(posedge clk); #1; end
        end
        check("first_sum", bus.out_sum, 7'd49);
        check("first_bit", bus.out_bit, 1'b1);

        // Backpressure: second window offered but refused while OUT is held
        thresh = 7'h3F; bus.in_valid = 1'b1; bus.in_img = 49'h0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_out", {bus.out_valid, bus.out_bit, bus.out_sum}, {1'b1, 1'b1, 7'd49});
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_img", dp_img, ALL1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; exp_cnt = 1;
        check("bp_cnt", win_cnt, 4'd1);
        check("bp_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; thresh = 7'h4F;
        check("next_clr", dp_clr, 1'b1);
        check("next_img", dp_img, 49'h0);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
        check("next_valid", bus.out_valid, 1'b1);
        check("next_sum", {bus.out_bit, bus.out_sum}, {1'b1, 7'h4F});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; exp_cnt = 2;
        check("next_cnt", win_cnt, 4'd2);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            do_window(tbl[i].img, 1'b1, tbl[i].w, tbl[i].thr, tbl[i].fen, tbl[i].fv,
                      i % 3, 1'b1, s, b);
            check("tbl_sum", s, tbl[i].es);
            check("tbl_bit", b, tbl[i].eb);
        end

        // Random windows against the popcount reference
        for (int i = 0; i < 30; i++) begin
            img = 49'({$urandom, $urandom});
            wd  = 49'({$urandom, $urandom});
            ld  = 1'($urandom);
            x   = ~(img ^ (ld ? wd : cur_w));
            es  = 7'(2 * $countones(x) - 49);
            s   = 7'($urandom);
            eb  = ($signed(es) >= $signed(s));
            do_window(img, ld, wd, s, 1'b0, 7'h00, int'($urandom_range(0, 3)), 1'($urandom), s, b);
            check("rnd_sum", s, es);
            check("rnd_bit", b, eb);
        end

        // Reset in the fifth ACCUM cycle abandons the window
        bus.in_valid = 1'b1; bus.in_img = 49'({$urandom, $urandom}) | 49'h1;
        w_load = 1'b1; w_data = 49'({$urandom, $urandom}) | 49'h1; thresh = 7'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; w_load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_step", dp_step, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_ctl", {bus.out_valid, busy, dp_clr, dp_step, bus.out_bit}, 5'b0);
        check("mid_rst_regs", {dp_img, dp_w, bus.out_sum, win_cnt}, 64'b0);
        exp_cnt = 0; cur_w = '0;
        @(negedge clk) rst = 1'b1;
        b = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            b = b | bus.out_valid;
        end
        check("rst_no_out", b, 1'b0);
        check("rst_release", {bus.in_ready, busy, win_cnt}, {1'b1, 1'b0, 4'd0});

        // Stream 2^CNT_W+1 windows back to back
        begin
            int cyc, acc_n, out_n, sum_bad;
            int clr_at[$];
            cyc = 0; acc_n = 0; out_n = 0; sum_bad = 0;
            bus.in_valid = 1'b1; bus.in_img = ALL1; w_load = 1'b1; w_data = ALL1;
            thresh = 7'd0; force_en = 1'b0; bus.out_ready = 1'b1;
            while ((acc_n < 17 || bus.out_valid || busy) && cyc < 400) begin
                if (dp_clr) clr_at.push_back(cyc);
                if (bus.out_valid) begin
                    out_n++;
                    if (bus.out_sum !== 7'd49 || bus.out_bit !== 1'b1) sum_bad++;
                end
                if (bus.in_valid && bus.in_ready) acc_n++;
                @(posedge clk); #1;
                cyc++;
                w_load = 1'b0;
                if (acc_n == 17) bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'b0;
            check("stream_timeout", 64'(cyc < 400), 64'd1);
            check("stream_accepted", 64'(acc_n), 64'd17);
            check("stream_outputs", 64'(out_n), 64'd17);
            check("stream_sums", 64'(sum_bad), 64'd0);
            check("stream_clrs", 64'(clr_at.size()), 64'd17);
            for (int i = 1; i < clr_at.size(); i++)
                check("stream_period", 64'(clr_at[i] - clr_at[i-1]), 64'd11);
            check("stream_wrap", win_cnt, 4'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bnn_window_sched.md
Name: bnn_window_sched

Overview:
- Scheduler for the binary XNOR/popcount row datapath.
- Accepts one 7x7 binary image window per valid/ready handshake and holds it stable. Holds a separately loaded 49-bit weight kernel.
- Sequences the datapath through clear plus 7 row-accumulate cycles, captures the signed popcount sum, thresholds it to a binarized activation and presents the result on a valid/ready output.
- Sits between the window-fetch logic and the next binarized layer.

Parameters:
- WIN_BITS, 49, window and weight width (7 rows x 7 bits).
- ROWS, 7, accumulate steps per window.
- SUM_W, 7, width of the signed datapath sum, threshold and output sum.
- CNT_W, 16, width of the processed-window counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  window offered.
- in_ready  out  1  scheduler can accept a window.
- in_img  in  WIN_BITS  binary image window.
- w_load  in  1  weight load strobe.
- w_ready  out  1  weight register may be written.
- w_data  in  WIN_BITS  weight kernel.
- thresh  in  SUM_W  signed activation threshold.
- dp_clr  out  1  synchronous clear to datapath (row counter and accumulator).
- dp_step  out  1  datapath accumulates one row on this edge.
- dp_img  out  WIN_BITS  latched window to datapath.
- dp_w  out  WIN_BITS  latched weights to datapath.
- dp_sum  in  SUM_W  signed datapath accumulator, registered.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  SUM_W  captured signed sum.
- out_bit  out  1  1 when out_sum >= thresh (signed compare).
- busy  out  1  state != IDLE.
- win_cnt  out  CNT_W  completed-output count.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - dp_img, dp_w, out_sum and win_cnt reset to 0.
  - out_bit, out_valid, dp_clr, dp_step and busy reset to 0.
  - in_ready and w_ready are 1 once in IDLE.
  - Reset mid-window abandons the window with no output.
- States are IDLE, CLEAR, ACCUM, SETTLE and OUT.
- IDLE:
  - in_ready=1 and w_ready=1.
  - When in_valid is 1: latch in_img into dp_img and go to CLEAR.
- CLEAR (1 cycle): dp_clr=1, then go to ACCUM with row counter=0.
- ACCUM (ROWS cycles):
  - dp_step=1 every cycle and the row counter increments.
  - After the step with row counter=ROWS-1, go to SETTLE.
  - dp_step is never asserted in any other state.
- SETTLE (1 cycle):
  - dp_sum is final.
  - Capture out_sum<=dp_sum and out_bit<=($signed(dp_sum) >= $signed(thresh)); thresh is sampled this cycle only.
  - Then go to OUT.
- OUT:
  - out_valid=1; out_sum and out_bit are held stable.
  - On out_ready=1: win_cnt increments (wraps at 2^CNT_W) and the state returns to IDLE.
  - Backpressure holds the OUT state indefinitely.
- Latency: handshake at cycle 0; CLEAR in cycle 1; ACCUM in cycles 2-8; SETTLE in cycle 9; out_valid first high in cycle 10. Minimum period is 11 cycles per window.
- Weights:
  - w_load with w_ready latches w_data into dp_w.
  - w_load outside IDLE is ignored.
  - w_load and an in_valid handshake in the same IDLE cycle: the new weights apply to that window.
- in_ready and w_ready are low outside IDLE. in_img is not sampled outside the handshake.
- dp_img and dp_w change only on a handshake or load. They are stable from CLEAR through SETTLE.
- Arithmetic: all sums and the compare are two's complement SUM_W. The scheduler performs no saturation; out_sum is whatever dp_sum holds.

Test Plan:
- Load w_data=all ones, send in_img=all ones, thresh=0, with a model datapath: dp_clr at cycle 1, dp_step high in cycles 2-8 only, out_valid rises in cycle 10, out_sum=49, out_bit=1, win_cnt=1.
- Hold out_ready=0 for 20 cycles after out_valid: out_sum and out_bit are stable, in_ready=0, a second in_valid is not accepted; release out_ready, then the next window is accepted one cycle later.
- Datapath returns dp_sum=-5, thresh=-5 gives out_bit=1; dp_sum=-6 gives out_bit=0.
- w_load during ACCUM with w_data=0: dp_w is unchanged. w_load together with in_valid in IDLE: dp_w takes the new value before CLEAR.
- Assert rst low in cycle 5 of ACCUM: all outputs are 0 immediately, no out_valid is produced, win_cnt=0, and in_ready=1 after release.
- Stream 2^CNT_W+1 windows with out_ready=1: consecutive windows are 11 cycles apart and win_cnt wraps to 1.
